// File: rtl/iob_native_arbiter.sv
// Round-robin arbiter sharing one native slave port among N_MASTERS requesters.
// Grant is held for a whole transaction; a watchdog completes transactions the slave never answers.
module iob_native_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8,
    localparam int GRANT_W  = $clog2(N_MASTERS),
    localparam int STRB_W   = DATA_W / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS*STRB_W-1:0]   m_wstrb,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [N_MASTERS-1:0]          m_ready,
    output logic                          s_valid,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [STRB_W-1:0]             s_wstrb,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_ready,
    output logic [GRANT_W-1:0]            grant,
    output logic                          busy,
    output logic                          timeout_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [GRANT_W-1:0]   grant_q, grant_d;
    logic [GRANT_W-1:0]   last_grant_q, last_grant_d;
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;

    logic                 found;
    logic [GRANT_W-1:0]   cand;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GRANT_W'(N_MASTERS - 1);
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wdog_q       <= wdog_d;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wdog_d       = wdog_q;
        m_ready      = '0;
        timeout_err  = 1'b0;
        found        = 1'b0;
        cand         = '0;

        case (state_q)
            IDLE: begin
                wdog_d = '0;
                // Scan starts just past the previous owner; indices >= N_MASTERS never occur.
                for (int k = 1; k <= N_MASTERS; k++) begin
                    cand = GRANT_W'((int'(last_grant_q) + k) % N_MASTERS);
                    if (!found && m_valid[cand]) begin
                        found   = 1'b1;
                        grant_d = cand;
                    end
                end
                if (found) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (s_ready) begin
                    m_ready[grant_q] = 1'b1;
                    last_grant_d     = grant_q;
                    state_d          = IDLE;
                    wdog_d           = '0;
                end else if (!m_valid[grant_q]) begin
                    // Master withdrew: release without completion and keep its priority.
                    state_d = IDLE;
                    wdog_d  = '0;
                end else if (wdog_q == '1) begin
                    m_ready[grant_q] = 1'b1;
                    timeout_err      = 1'b1;
                    last_grant_d     = grant_q;
                    state_d          = IDLE;
                    wdog_d           = '0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q == BUSY);
    assign grant   = grant_q;
    assign s_valid = busy && m_valid[grant_q];
    assign s_addr  = m_addr[int'(grant_q)*ADDR_W +: ADDR_W];
    assign s_wdata = m_wdata[int'(grant_q)*DATA_W +: DATA_W];
    assign s_wstrb = s_valid ? m_wstrb[int'(grant_q)*STRB_W +: STRB_W] : '0;
    assign m_rdata = timeout_err ? '1 : s_rdata;

endmodule

// File: tb/tb_iob_native_arbiter.sv
// Directed bench for iob_native_arbiter: a 2-master instance with a short watchdog
// and a 3-master instance for the non-power-of-two scan.
module tb_iob_native_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 2-master instance, TIMEOUT_W = 4
    logic [1:0]  m_valid2;
    logic [63:0] m_addr2, m_wdata2;
    logic [7:0]  m_wstrb2;
    logic [31:0] m_rdata2;
    logic [1:0]  m_ready2;
    logic        s_valid2;
    logic [31:0] s_addr2, s_wdata2;
    logic [3:0]  s_wstrb2;
    logic [31:0] s_rdata2;
    logic        s_ready2;
    logic [0:0]  grant2;
    logic        busy2, to2;

    // 3-master instance, default watchdog
    logic [2:0]  m_valid3;
    logic [95:0] m_addr3, m_wdata3;
    logic [11:0] m_wstrb3;
    logic [31:0] m_rdata3;
    logic [2:0]  m_ready3;
    logic        s_valid3;
    logic [31:0] s_addr3, s_wdata3;
    logic [3:0]  s_wstrb3;
    logic [31:0] s_rdata3;
    logic        s_ready3;
    logic [1:0]  grant3;
    logic        busy3, to3;

    iob_native_arbiter #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT_W(4)) dut2 (
        .clk(clk), .rst(rst),
        .m_valid(m_valid2), .m_addr(m_addr2), .m_wdata(m_wdata2), .m_wstrb(m_wstrb2),
        .m_rdata(m_rdata2), .m_ready(m_ready2),
        .s_valid(s_valid2), .s_addr(s_addr2), .s_wdata(s_wdata2), .s_wstrb(s_wstrb2),
        .s_rdata(s_rdata2), .s_ready(s_ready2),
        .grant(grant2), .busy(busy2), .timeout_err(to2)
    );

    iob_native_arbiter #(.N_MASTERS(3), .ADDR_W(32), .DATA_W(32), .TIMEOUT_W(8)) dut3 (
        .clk(clk), .rst(rst),
        .m_valid(m_valid3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_wstrb(m_wstrb3),
        .m_rdata(m_rdata3), .m_ready(m_ready3),
        .s_valid(s_valid3), .s_addr(s_addr3), .s_wdata(s_wdata3), .s_wstrb(s_wstrb3),
        .s_rdata(s_rdata3), .s_ready(s_ready3),
        .grant(grant3), .busy(busy3), .timeout_err(to3)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got hang, expected finish");
        $fatal(1);
    end

    initial begin
        int cnt0, cnt1, fired;

        m_valid2 = '0;
        m_addr2  = {32'h20, 32'h10};
        m_wdata2 = {32'hB, 32'hA};
        m_wstrb2 = '0;
        s_rdata2 = '0;
        s_ready2 = 1'b0;
        m_valid3 = '0;
        m_addr3  = {32'h300, 32'h200, 32'h100};
        m_wdata3 = {32'h12345678, 32'h22, 32'h11};
        m_wstrb3 = {4'hF, 4'h0, 4'h3};
        s_rdata3 = '0;
        s_ready3 = 1'b0;

        // Reset state
        #12;
        check("rst_s_valid", s_valid2, 0);
        check("rst_busy",    busy2,    0);
        check("rst_m_ready", m_ready2, 0);
        check("rst_grant",   grant2,   0);
        check("rst_timeout", to2,      0);
        check("rst_s_addr",  s_addr2,  32'h10);
        check("rst_s_wdata", s_wdata2, 32'hA);
        check("rst_s_wstrb3_gated", s_wstrb3, 0);
        check("rst_s_addr3", s_addr3,  32'h100);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: master 0 read, slave answers in the 4th BUSY cycle
        m_valid2 = 2'b01;
        sample();
        check("t1_idle_s_valid", s_valid2, 0);
        tick();
        for (int c = 1; c <= 3; c++) begin
            sample();
            check("t1_s_valid", s_valid2, 1);
            check("t1_busy",    busy2,    1);
            check("t1_grant",   grant2,   0);
            check("t1_m_ready", m_ready2, 0);
            check("t1_s_addr",  s_addr2,  32'h10);
            tick();
        end
        s_ready2 = 1'b1;
        s_rdata2 = 32'hCAFE;
        sample();
        check("t1_ready_m_ready", m_ready2, 2'b01);
        check("t1_ready_rdata",   m_rdata2, 32'hCAFE);
        tick();
        s_ready2 = 1'b0;
        m_valid2 = 2'b00;
        sample();
        check("t1_done_busy",    busy2,    0);
        check("t1_done_s_valid", s_valid2, 0);
        // Stray ready while idle is ignored
        s_ready2 = 1'b1;
        sample();
        check("t1_idle_ready_ignored", m_ready2, 0);
        tick();
        s_ready2 = 1'b0;
        sample();
        check("t1_idle_stays", busy2, 0);

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // 2: both masters requesting continuously -> grants alternate from master 0
        m_valid2 = 2'b11;
        cnt0 = 0;
        cnt1 = 0;
        for (int t = 0; t < 8; t++) begin
            sample();
            check("t2_idle", busy2, 0);
            tick();
            sample();
            check("t2_grant",   grant2,   t % 2);
            check("t2_s_valid", s_valid2, 1);
            check("t2_s_addr",  s_addr2,  (t % 2) ? 32'h20 : 32'h10);
            tick();
            s_ready2 = 1'b1;
            sample();
            check("t2_m_ready", m_ready2, (t % 2) ? 2'b10 : 2'b01);
            if (m_ready2[0]) cnt0++;
            if (m_ready2[1]) cnt1++;
            if (t == 3) begin
                check("t2_cnt0_at4", cnt0, 2);
                check("t2_cnt1_at4", cnt1, 2);
            end
            tick();
            s_ready2 = 1'b0;
        end
        m_valid2 = 2'b00;
        check("t2_cnt0", cnt0, 4);
        check("t2_cnt1", cnt1, 4);

        // 4: watchdog fires in BUSY cycle 16 (count reaches 15 with no ready)
        s_rdata2 = 32'h1234;
        m_valid2 = 2'b01;
        tick();
        fired = 0;
        for (int c = 1; c <= 40; c++) begin
            sample();
            if (to2) begin
                fired = c;
                check("t4_m_ready", m_ready2, 2'b01);
                check("t4_rdata",   m_rdata2, 32'hFFFF_FFFF);
                break;
            end
            tick();
        end
        check("t4_fire_cycle", fired, 16);
        tick();
        m_valid2 = 2'b00;
        sample();
        check("t4_idle_busy",   busy2, 0);
        check("t4_pulse_ended", to2,   0);

        // 4b: ready coinciding with the timeout cycle wins
        m_valid2 = 2'b01;
        tick();
        for (int c = 1; c < 16; c++) tick();
        s_ready2 = 1'b1;
        s_rdata2 = 32'h5555;
        sample();
        check("t4b_no_err",  to2,      0);
        check("t4b_m_ready", m_ready2, 2'b01);
        check("t4b_rdata",   m_rdata2, 32'h5555);
        tick();
        s_ready2 = 1'b0;
        m_valid2 = 2'b00;
        sample();
        check("t4b_idle", busy2, 0);

        // 5: master 1 drops valid in BUSY cycle 2; it keeps first priority
        m_valid2 = 2'b10;
        tick();
        sample();
        check("t5_grant",   grant2,   1);
        check("t5_s_valid", s_valid2, 1);
        tick();
        m_valid2 = 2'b00;
        sample();
        check("t5_drop_s_valid", s_valid2, 0);
        check("t5_drop_m_ready", m_ready2, 0);
        tick();
        sample();
        check("t5_drop_idle", busy2, 0);
        m_valid2 = 2'b11;
        tick();
        sample();
        check("t5_same_master_first", grant2, 1);
        tick();
        s_ready2 = 1'b1;
        sample();
        check("t5_m_ready", m_ready2, 2'b10);
        tick();
        s_ready2 = 1'b0;
        m_valid2 = 2'b00;

        // 6: reset mid-BUSY aborts immediately; master 0 wins afterwards
        m_valid2 = 2'b01;
        tick();
        s_ready2 = 1'b1;
        sample();
        check("t6_pre_m_ready", m_ready2, 2'b01);
        tick();
        s_ready2 = 1'b0;
        m_valid2 = 2'b11;
        tick();
        sample();
        check("t6_grant_before_rst", grant2, 1);
        s_ready2 = 1'b1;
        #1;
        check("t6_would_complete", m_ready2, 2'b10);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_s_valid", s_valid2, 0);
        check("t6_rst_m_ready", m_ready2, 0);
        check("t6_rst_busy",    busy2,    0);
        s_ready2 = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        sample();
        check("t6_after_rst_grant", grant2, 0);
        tick();
        s_ready2 = 1'b1;
        sample();
        check("t6_after_rst_m_ready", m_ready2, 2'b01);
        tick();
        s_ready2 = 1'b0;
        m_valid2 = 2'b00;

        // 3: three masters, non-power-of-two wrap
        m_valid3 = 3'b001;
        sample();
        check("t3_idle_wstrb_gated", s_wstrb3, 0);
        tick();
        s_ready3 = 1'b1;
        sample();
        check("t3_grant0",   grant3,   0);
        check("t3_wstrb0",   s_wstrb3, 4'h3);
        check("t3_m_ready0", m_ready3, 3'b001);
        tick();
        s_ready3 = 1'b0;
        m_valid3 = 3'b101;
        sample();
        check("t3_idle", busy3, 0);
        tick();
        s_ready3 = 1'b1;
        sample();
        check("t3_grant2",   grant3,   2);
        check("t3_wdata2",   s_wdata3, 32'h12345678);
        check("t3_wstrb2",   s_wstrb3, 4'hF);
        check("t3_addr2",    s_addr3,  32'h300);
        check("t3_m_ready2", m_ready3, 3'b100);
        tick();
        s_ready3 = 1'b0;
        m_valid3 = 3'b011;
        tick();
        s_ready3 = 1'b1;
        sample();
        check("t3_wrap_grant0", grant3, 0);
        tick();
        s_ready3 = 1'b0;
        m_valid3 = 3'b110;
        tick();
        s_ready3 = 1'b1;
        sample();
        check("t3_grant1",   grant3,   1);
        check("t3_m_ready1", m_ready3, 3'b010);
        tick();
        s_ready3 = 1'b0;
        m_valid3 = 3'b000;
        sample();
        check("t3_end_idle", busy3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
